// File: rtl/bitwise_unit.sv
// Single-stage bitwise ALU with a valid/ready handshake, an XOR accumulator and
// a transaction counter. Results are registered one cycle after acceptance.
module bitwise_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] txn_count
);

    localparam logic [2:0] OP_NOT     = 3'b000;
    localparam logic [2:0] OP_AND     = 3'b001;
    localparam logic [2:0] OP_OR      = 3'b010;
    localparam logic [2:0] OP_XOR     = 3'b011;
    localparam logic [2:0] OP_NAND    = 3'b100;
    localparam logic [2:0] OP_NOR     = 3'b101;
    localparam logic [2:0] OP_ACC_XOR = 3'b110;
    localparam logic [2:0] OP_ACC_CLR = 3'b111;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] txn_count_q, txn_count_d;
    logic [WIDTH-1:0] result;
    logic             accept;

    function automatic logic [WIDTH-1:0] compute(
        input logic [2:0]       f_op,
        input logic [WIDTH-1:0] f_a,
        input logic [WIDTH-1:0] f_b,
        input logic [WIDTH-1:0] f_acc
    );
        logic [WIDTH-1:0] r;
        case (f_op)
            OP_NOT:     r = ~f_a;
            OP_AND:     r = f_a & f_b;
            OP_OR:      r = f_a | f_b;
            OP_XOR:     r = f_a ^ f_b;
            OP_NAND:    r = ~(f_a & f_b);
            OP_NOR:     r = ~(f_a | f_b);
            OP_ACC_XOR: r = f_acc ^ f_a;
            OP_ACC_CLR: r = f_acc;
            default:    r = '0;
        endcase
        return r;
    endfunction

    // The result slot is free when empty or being drained this very cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        result      = compute(op, a, b, acc_q);
        out_d       = out_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        txn_count_d = txn_count_q;
        if (accept) begin
            out_d       = result;
            out_valid_d = 1'b1;
            txn_count_d = txn_count_q + CNT_W'(1);
            if (op == OP_ACC_XOR) begin
                acc_d = result;
            end else if (op == OP_ACC_CLR) begin
                acc_d = '0;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            acc_q       <= '0;
            txn_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            acc_q       <= acc_d;
            txn_count_q <= txn_count_d;
        end
    end

    // Flags decode the registered result so they always agree with out.
    assign out       = out_q;
    assign zr        = (out_q == '0);
    assign ng        = out_q[WIDTH-1];
    assign out_valid = out_valid_q;
    assign acc       = acc_q;
    assign txn_count = txn_count_q;

endmodule

// File: tb/tb_bitwise_unit.sv
// Bench for bitwise_unit: directed vector table, handshake corner sequences,
// async reset, a narrow counter-wrap instance and randomized model comparison.
module tb_bitwise_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out;
    logic        zr;
    logic        ng;
    logic [15:0] acc;
    logic [15:0] txn_count;

    logic        w8_in_valid = 1'b0;
    logic        w8_in_ready;
    logic [2:0]  w8_op = 3'b000;
    logic [7:0]  w8_a = '0;
    logic [7:0]  w8_b = '0;
    logic        w8_out_valid;
    logic        w8_out_ready = 1'b1;
    logic [7:0]  w8_out;
    logic        w8_zr;
    logic        w8_ng;
    logic [7:0]  w8_acc;
    logic [3:0]  w8_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bitwise_unit #(.WIDTH(16), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .zr(zr), .ng(ng), .acc(acc), .txn_count(txn_count)
    );

    bitwise_unit #(.WIDTH(8), .CNT_W(4)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(w8_in_valid), .in_ready(w8_in_ready),
        .op(w8_op), .a(w8_a), .b(w8_b), .out_valid(w8_out_valid), .out_ready(w8_out_ready),
        .out(w8_out), .zr(w8_zr), .ng(w8_ng), .acc(w8_acc), .txn_count(w8_cnt)
    );

    // Reference state: what the block should hold after each edge.
    logic        m_valid = 1'b0;
    logic [15:0] m_out   = '0;
    logic [15:0] m_acc   = '0;
    logic [15:0] m_cnt   = '0;

    typedef struct {
        logic        vld;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        ordy;
        logic [15:0] e_out;
        logic        e_zr;
        logic        e_ng;
        logic [15:0] e_acc;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_res(input logic [2:0] f_op, input logic [15:0] fa,
                                            input logic [15:0] fb, input logic [15:0] facc);
        case (f_op)
            3'd0:    return ~fa;
            3'd1:    return fa & fb;
            3'd2:    return fa | fb;
            3'd3:    return fa ^ fb;
            3'd4:    return ~(fa & fb);
            3'd5:    return ~(fa | fb);
            3'd6:    return facc ^ fa;
            default: return facc;
        endcase
    endfunction

    // Drive one cycle's inputs, check in_ready before the edge, advance the model.
    task automatic cycle(input logic v, input logic [2:0] o, input logic [15:0] av,
                         input logic [15:0] bv, input logic ordy);
        logic take;
        in_valid  = v;
        op        = o;
        a         = av;
        b         = bv;
        out_ready = ordy;
        #1;
        chk("in_ready", 64'(in_ready), 64'(!m_valid || ordy));
        take = v && (!m_valid || ordy);
        @(posedge clk);
        #1;
        if (take) begin
            m_out   = ref_res(o, av, bv, m_acc);
            if (o == 3'd6) m_acc = m_out;
            if (o == 3'd7) m_acc = '0;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 16'd1;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".out"},       64'(out),       64'(m_out));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
        chk({tag, ".acc"},       64'(acc),       64'(m_acc));
        chk({tag, ".txn_count"}, 64'(txn_count), 64'(m_cnt));
        chk({tag, ".zr"},        64'(zr),        64'(m_out == 16'd0));
        chk({tag, ".ng"},        64'(ng),        64'(m_out[15]));
    endtask

    initial begin
        tbl[0] = '{1'b1, 3'd0, 16'hAAAA, 16'h0F0F, 1'b1, 16'h5555, 1'b0, 1'b0, 16'h0000, 16'd1};
        tbl[1] = '{1'b1, 3'd1, 16'hAAAA, 16'h0F0F, 1'b1, 16'h0A0A, 1'b0, 1'b0, 16'h0000, 16'd2};
        tbl[2] = '{1'b1, 3'd2, 16'hAAAA, 16'h0F0F, 1'b1, 16'hAFAF, 1'b0, 1'b1, 16'h0000, 16'd3};
        tbl[3] = '{1'b1, 3'd3, 16'hAAAA, 16'h0F0F, 1'b1, 16'hA5A5, 1'b0, 1'b1, 16'h0000, 16'd4};
        tbl[4] = '{1'b1, 3'd4, 16'hAAAA, 16'h0F0F, 1'b1, 16'hF5F5, 1'b0, 1'b1, 16'h0000, 16'd5};
        tbl[5] = '{1'b1, 3'd5, 16'hAAAA, 16'h0F0F, 1'b1, 16'h5050, 1'b0, 1'b0, 16'h0000, 16'd6};
        tbl[6] = '{1'b1, 3'd6, 16'h00FF, 16'h0000, 1'b1, 16'h00FF, 1'b0, 1'b0, 16'h00FF, 16'd7};
        tbl[7] = '{1'b1, 3'd6, 16'hFFFF, 16'h0000, 1'b1, 16'hFF00, 1'b0, 1'b1, 16'hFF00, 16'd8};
        tbl[8] = '{1'b1, 3'd7, 16'h0000, 16'h0000, 1'b1, 16'hFF00, 1'b0, 1'b1, 16'h0000, 16'd9};
        tbl[9] = '{1'b1, 3'd3, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'd10};

        // Reset state, observed before any clock edge.
        #1;
        chk("rst.out",       64'(out),       64'h0);
        chk("rst.out_valid", 64'(out_valid), 64'h0);
        chk("rst.acc",       64'(acc),       64'h0);
        chk("rst.txn_count", 64'(txn_count), 64'h0);
        chk("rst.zr",        64'(zr),        64'h1);
        chk("rst.ng",        64'(ng),        64'h0);
        chk("rst.in_ready",  64'(in_ready),  64'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed vectors: basic ops, accumulator, zero result.
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].vld, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ordy);
            chk($sformatf("vec%0d.out", i),       64'(out),       64'(tbl[i].e_out));
            chk($sformatf("vec%0d.zr", i),        64'(zr),        64'(tbl[i].e_zr));
            chk($sformatf("vec%0d.ng", i),        64'(ng),        64'(tbl[i].e_ng));
            chk($sformatf("vec%0d.acc", i),       64'(acc),       64'(tbl[i].e_acc));
            chk($sformatf("vec%0d.txn_count", i), 64'(txn_count), 64'(tbl[i].e_cnt));
            chk($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'h1);
        end

        // Backpressure: drain, then hold in_valid with out_ready low.
        cycle(1'b0, 3'd0, 16'h0, 16'h0, 1'b1);
        chk("drain.out_valid", 64'(out_valid), 64'h0);
        cycle(1'b1, 3'd0, 16'h1111, 16'h0, 1'b0);
        chk("bp0.out", 64'(out), 64'hEEEE);
        chk("bp0.txn_count", 64'(txn_count), 64'd11);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 3'd1, 16'hFFFF, 16'hFFFF, 1'b0);
            chk("bp.in_ready_low", 64'(in_ready), 64'h0);
            chk("bp.out_stable", 64'(out), 64'hEEEE);
            chk("bp.out_valid", 64'(out_valid), 64'h1);
            chk("bp.txn_count", 64'(txn_count), 64'd11);
        end
        cycle(1'b1, 3'd2, 16'h1234, 16'h0001, 1'b1);
        chk("bp.release.out", 64'(out), 64'h1235);
        chk("bp.release.out_valid", 64'(out_valid), 64'h1);
        chk("bp.release.txn_count", 64'(txn_count), 64'd12);
        chk_model("bp");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), 16'($urandom),
                  16'($urandom), $urandom_range(0, 3) != 0);
            chk_model("rnd");
        end

        // Async reset mid-stream with a known accumulator.
        cycle(1'b1, 3'd7, 16'h0, 16'h0, 1'b1);
        cycle(1'b1, 3'd6, 16'h00FF, 16'h0, 1'b1);
        chk("pre_rst.acc", 64'(acc), 64'h00FF);
        in_valid = 1'b1;
        op       = 3'd6;
        a        = 16'h0F0F;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.acc",       64'(acc),       64'h0);
        chk("arst.out",       64'(out),       64'h0);
        chk("arst.out_valid", 64'(out_valid), 64'h0);
        chk("arst.txn_count", 64'(txn_count), 64'h0);
        chk("arst.zr",        64'(zr),        64'h1);
        chk("arst.in_ready",  64'(in_ready),  64'h1);
        m_valid = 1'b0;
        m_out   = '0;
        m_acc   = '0;
        m_cnt   = '0;
        @(posedge clk);
        #1;
        chk("arst.hold.acc", 64'(acc), 64'h0);
        rst_n = 1'b1;
        cycle(1'b1, 3'd6, 16'h00F0, 16'h0, 1'b1);
        chk("post_rst.first_accept", 64'(txn_count), 64'd1);
        chk("post_rst.acc", 64'(acc), 64'h00F0);
        chk_model("post_rst");
        in_valid = 1'b0;

        // Narrow instance: width 8 inversion and 4-bit counter wrap.
        w8_in_valid  = 1'b1;
        w8_out_ready = 1'b1;
        w8_op        = 3'd0;
        w8_a         = 8'h0F;
        @(posedge clk);
        #1;
        chk("w8.out", 64'(w8_out), 64'hF0);
        chk("w8.ng",  64'(w8_ng),  64'h1);
        chk("w8.cnt", 64'(w8_cnt), 64'd1);
        for (int i = 0; i < 16; i++) begin
            w8_op = 3'($urandom_range(0, 5));
            w8_a  = 8'($urandom);
            w8_b  = 8'($urandom);
            @(posedge clk);
            #1;
            if (i == 14) chk("w8.wrap_zero", 64'(w8_cnt), 64'd0);
        end
        chk("w8.wrap_cnt", 64'(w8_cnt), 64'd1);
        chk("w8.out_valid", 64'(w8_out_valid), 64'h1);
        w8_in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bitwise_unit.md
BITWISE_UNIT -- requirements
Module: bitwise_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, which sets the operand/result width in bits (legal range 1..64).
REQ-002 SHALL have parameter CNT_W, default 16, which sets the transaction counter width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: the upstream operation is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept an operation this cycle.
REQ-007 SHALL have port op, input, 3 bits: the operation select.
REQ-008 SHALL have port a, input, WIDTH bits: operand A.
REQ-009 SHALL have port b, input, WIDTH bits: operand B.
REQ-010 SHALL have port out_valid, output, 1 bit: the result register holds an unconsumed result.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port out, output, WIDTH bits: the registered result.
REQ-013 SHALL have port zr, output, 1 bit: high when out is all zeros.
REQ-014 SHALL have port ng, output, 1 bit: equal to out[WIDTH-1].
REQ-015 SHALL have port acc, output, WIDTH bits: the current accumulator value.
REQ-016 SHALL have port txn_count, output, CNT_W bits: the number of accepted operations.

Function
REQ-017 SHALL define an accepted operation ("accept") as in_valid && in_ready sampled at a rising clk edge.
REQ-018 SHALL drive in_ready = !out_valid || out_ready, combinationally, with no dependence on in_valid.
REQ-019 SHALL capture the result into out, zr and ng on the edge of an accept, giving a latency of exactly 1 cycle.
REQ-020 SHALL compute the result per op:
- 000: ~a
- 001: a&b
- 010: a|b
- 011: a^b
- 100: ~(a&b)
- 101: ~(a|b)
- 110 ACC_XOR: acc^a
- 111 ACC_CLR: the old acc
REQ-021 SHALL, on accept of ACC_XOR, load acc with acc^a, the same value that is written to out.
REQ-022 SHALL, on accept of ACC_CLR, load acc with 0 while out receives the pre-clear acc value.
REQ-023 SHALL leave acc unchanged on accept of ops 000-101 and in every cycle without an accept.
REQ-024 SHALL set out_valid on an accept.
REQ-025 SHALL clear out_valid when out_valid && out_ready && no accept occurs in that cycle.
REQ-026 SHALL keep out_valid high and replace out when a consume and an accept occur in the same cycle (back-to-back throughput of 1 operation per cycle).
REQ-027 SHALL hold out, zr, ng and out_valid stable while out_valid && !out_ready (backpressure); no operation is accepted in that state.
REQ-028 SHALL increment txn_count by 1 on each accept, wrapping from 2^CNT_W-1 to 0.
REQ-029 SHALL ignore a, b and op when no accept occurs, and no state SHALL change as a result.
REQ-030 SHALL derive zr and ng from the registered out only, never from the inputs directly.
REQ-031 SHALL make out_valid, out, acc and txn_count registers; in_ready is the only combinational output.

Reset
REQ-032 SHALL, while rst_n is low, force the following registers to 0, asynchronously and regardless of clk:
- out_valid, out, acc and txn_count = 0
- zr = 1, consistent with out = 0
- ng = 0
REQ-033 SHALL drive in_ready = 1 during and after reset, since out_valid = 0.
REQ-034 SHALL discard any operation or result in flight when rst_n is asserted mid-operation, with no partial update of acc.
REQ-035 SHALL allow the first accept on the first rising edge after rst_n deasserts.

Verification
REQ-036 SHALL cover the basic ops: WIDTH=16, out_ready=1, a=16'hAAAA, b=16'h0F0F, op 000..101 one per cycle -> out per cycle = 5555, 0A0A, AFAF, A5A5, F5F5, 5050; ng=1 on AFAF, A5A5 and F5F5; txn_count=6.
REQ-037 SHALL cover the accumulator: ACC_XOR a=16'h00FF, then ACC_XOR a=16'hFFFF, then ACC_CLR -> out = 00FF, FF00, FF00; acc = 0 after the clear; zr=0 throughout.
REQ-038 SHALL cover backpressure: out_ready=0 with in_valid held high for 3 cycles -> only the first op is accepted, in_ready=0, and out is stable; raising out_ready with the same-cycle accept -> the next result appears one cycle later with out_valid staying 1.
REQ-039 SHALL cover zero and width: op 011 with a=b=16'h1234 -> out=0, zr=1; a WIDTH=8 instance with op 000 and a=8'h0F -> out=8'hF0.
REQ-040 SHALL cover async reset: rst_n pulled low between clock edges mid-stream with acc=16'h00FF -> acc, out, out_valid and txn_count read 0 immediately, before the next edge, and in_ready=1.
REQ-041 SHALL cover counter wrap: CNT_W=4 with 17 accepts -> txn_count=1.
